// File: rtl/display_mode_ctrl_pkg.sv
// Shared definitions for the display mode controller.
//  - state_t  : controller states (3-bit encoding)
//  - DSEL_*   : display mux view codes driven on disp_sel
//  - SRC_*    : which event raised the current alert
//  - view_sel : maps a state (and alert source) onto a display view code
package display_mode_ctrl_pkg;

    typedef enum logic [2:0] {
        S_TIME   = 3'd0,
        S_STW    = 3'd1,
        S_TMR    = 3'd2,
        S_ALMSET = 3'd3,
        S_ALERT  = 3'd4
    } state_t;

    localparam logic [1:0] DSEL_TIME = 2'd0;
    localparam logic [1:0] DSEL_STW  = 2'd1;
    localparam logic [1:0] DSEL_TMR  = 2'd2;
    localparam logic [1:0] DSEL_ALM  = 2'd3;

    localparam logic SRC_ALM = 1'b0;
    localparam logic SRC_TMR = 1'b1;

    // An alarm alert shows the time of day; a timer alert shows the expired timer.
    function automatic logic [1:0] view_sel(input state_t st, input logic src);
        logic [1:0] sel;
        case (st)
            S_TIME:   sel = DSEL_TIME;
            S_STW:    sel = DSEL_STW;
            S_TMR:    sel = DSEL_TMR;
            S_ALMSET: sel = DSEL_ALM;
            S_ALERT:  sel = (src == SRC_TMR) ? DSEL_TMR : DSEL_TIME;
            default:  sel = DSEL_TIME;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/display_mode_ctrl_debounce.sv
// btn_debounce: synchronises a raw asynchronous button and filters bounce.
// The stable level only follows the synchronised input after DBNC_CYC
// consecutive equal samples that differ from it. A one-clk press pulse is
// produced on a stable 0->1 transition only; release gives no pulse.
// Latency from a raw rising edge to the press pulse is DBNC_CYC+2 clocks.
// Ports:
//  clk   in  system clock
//  reset in  asynchronous active-low reset
//  raw   in  raw button level (asynchronous)
//  press out one-clk pulse per debounced press
module btn_debounce
    import display_mode_ctrl_pkg::*;
#(
    parameter int DBNC_CYC = 1_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic press
);

    localparam int CW = (DBNC_CYC < 1) ? 1 : $clog2(DBNC_CYC + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DBNC_CYC - 1);

    logic          sync_1_r;
    logic          sync_2_r;
    logic          stable_r;
    logic [CW-1:0] cnt_r;

    // Two-flop synchroniser for the asynchronous button input.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_1_r <= 1'b0;
            sync_2_r <= 1'b0;
        end else begin
            sync_1_r <= raw;
            sync_2_r <= sync_1_r;
        end
    end

    // Stability counter; any sample equal to the stable level restarts the count.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stable_r <= 1'b0;
            cnt_r    <= '0;
            press    <= 1'b0;
        end else if (sync_2_r != stable_r) begin
            if (cnt_r >= CNT_LAST) begin
                stable_r <= sync_2_r;
                cnt_r    <= '0;
                press    <= sync_2_r;
            end else begin
                cnt_r    <= cnt_r + CW'(1);
                press    <= 1'b0;
            end
        end else begin
            cnt_r <= '0;
            press <= 1'b0;
        end
    end

endmodule

// File: rtl/display_mode_ctrl.sv
// display_mode_ctrl: sequences the clock's user modes and arbitrates the
// 4-digit display between time, stopwatch, timer and alarm-set views.
// An alarm ring or timer expiry preempts the view (ALERT), flashes the
// display and returns to the previous view on acknowledge.
// Ports:
//  clk        in   system clock
//  reset      in   asynchronous active-low reset
//  tick_1hz   in   one-clk strobe per second
//  btn_mode   in   raw mode button
//  btn_ack    in   raw acknowledge button
//  alarm_ring in   level, high while the alarm rings
//  timer_done in   one-clk pulse at timer expiry
//  disp_sel   out  view select 0=TIME 1=STW 2=TMR 3=ALM
//  stw/tmren/almen out  one-hot-or-zero decode of disp_sel
//  blank      out  display blank during ALERT flash
//  alert      out  high in ALERT
//  mode_chg   out  one-clk pulse when disp_sel changes
module display_mode_ctrl
    import display_mode_ctrl_pkg::*;
#(
    parameter int DBNC_CYC = 1_000_000,
    parameter int IDLE_SEC = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick_1hz,
    input  logic       btn_mode,
    input  logic       btn_ack,
    input  logic       alarm_ring,
    input  logic       timer_done,
    output logic [1:0] disp_sel,
    output logic       stw,
    output logic       tmren,
    output logic       almen,
    output logic       blank,
    output logic       alert,
    output logic       mode_chg
);

    localparam int IW = (IDLE_SEC < 1) ? 1 : $clog2(IDLE_SEC + 1);
    localparam logic [IW-1:0] IDLE_LAST = IW'(IDLE_SEC - 1);

    logic mode_press_s;
    logic ack_press_s;

    btn_debounce #(.DBNC_CYC(DBNC_CYC)) u_dbnc_mode (
        .clk   (clk),
        .reset (reset),
        .raw   (btn_mode),
        .press (mode_press_s)
    );

    btn_debounce #(.DBNC_CYC(DBNC_CYC)) u_dbnc_ack (
        .clk   (clk),
        .reset (reset),
        .raw   (btn_ack),
        .press (ack_press_s)
    );

    state_t        state_r;
    state_t        saved_r;
    logic          src_r;
    logic          pend_r;
    logic [IW-1:0] idle_r;
    logic          ring_q_r;

    state_t        state_s;
    state_t        saved_s;
    logic          src_s;
    logic          pend_s;
    logic [IW-1:0] idle_s;
    logic          blank_s;
    logic [1:0]    dsel_s;
    logic          ring_rise_s;
    logic          ring_fall_s;
    logic          exit_s;

    assign ring_rise_s = alarm_ring & ~ring_q_r;
    assign ring_fall_s = ~alarm_ring & ring_q_r;

    // Next-state logic for the mode sequencer and alert preemption.
    always_comb begin
        state_s = state_r;
        saved_s = saved_r;
        src_s   = src_r;
        pend_s  = pend_r;
        idle_s  = idle_r;
        blank_s = blank;
        exit_s  = 1'b0;

        if (state_r != S_ALERT) begin
            if (ring_rise_s || timer_done) begin
                // Alert entry wins over a same-cycle mode press; the alarm
                // is shown first and a coincident timer expiry is queued.
                state_s = S_ALERT;
                saved_s = state_r;
                src_s   = ring_rise_s ? SRC_ALM : SRC_TMR;
                pend_s  = ring_rise_s & timer_done;
                blank_s = 1'b0;
            end else begin
                case (state_r)
                    S_TIME:   state_s = mode_press_s ? S_STW : S_TIME;
                    S_STW:    state_s = mode_press_s ? S_TMR : S_STW;
                    S_TMR:    state_s = mode_press_s ? S_ALMSET : S_TMR;
                    S_ALMSET: begin
                        if (mode_press_s) begin
                            state_s = S_TIME;
                        end else if (ack_press_s) begin
                            idle_s = '0;
                        end else if (tick_1hz) begin
                            if (idle_r >= IDLE_LAST) begin
                                state_s = S_TIME;
                            end else begin
                                idle_s = idle_r + IW'(1);
                            end
                        end else begin
                            idle_s = idle_r;
                        end
                    end
                    default:  state_s = S_TIME;
                endcase
            end
        end else begin
            if (src_r == SRC_ALM && timer_done) begin
                pend_s = 1'b1;
            end else begin
                pend_s = pend_r;
            end
            if (tick_1hz) begin
                blank_s = ~blank;
            end else begin
                blank_s = blank;
            end
            exit_s = ack_press_s || (src_r == SRC_ALM && ring_fall_s);
            if (exit_s) begin
                blank_s = 1'b0;
                if (pend_s) begin
                    // A queued timer alert takes over instead of leaving ALERT.
                    src_s  = SRC_TMR;
                    pend_s = 1'b0;
                end else begin
                    state_s = saved_r;
                end
            end else begin
                state_s = S_ALERT;
            end
        end

        // The idle count only survives while staying inside ALMSET.
        if (state_s != S_ALMSET || state_r != S_ALMSET) begin
            idle_s = '0;
        end else begin
            idle_s = idle_s;
        end

        dsel_s = view_sel(state_s, src_s);
    end

    // State, context and registered output update.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r  <= S_TIME;
            saved_r  <= S_TIME;
            src_r    <= SRC_ALM;
            pend_r   <= 1'b0;
            idle_r   <= '0;
            ring_q_r <= 1'b0;
            disp_sel <= DSEL_TIME;
            stw      <= 1'b0;
            tmren    <= 1'b0;
            almen    <= 1'b0;
            blank    <= 1'b0;
            alert    <= 1'b0;
            mode_chg <= 1'b0;
        end else begin
            state_r  <= state_s;
            saved_r  <= saved_s;
            src_r    <= src_s;
            pend_r   <= pend_s;
            idle_r   <= idle_s;
            ring_q_r <= alarm_ring;
            disp_sel <= dsel_s;
            stw      <= (dsel_s == DSEL_STW);
            tmren    <= (dsel_s == DSEL_TMR);
            almen    <= (dsel_s == DSEL_ALM);
            blank    <= blank_s;
            alert    <= (state_s == S_ALERT);
            mode_chg <= (dsel_s != disp_sel);
        end
    end

endmodule

// File: tb/tb_display_mode_ctrl.sv
// Self-checking bench for display_mode_ctrl (DBNC_CYC=4, IDLE_SEC=3).
module tb_display_mode_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       tick_1hz = 1'b0;
    logic       btn_mode = 1'b0;
    logic       btn_ack = 1'b0;
    logic       alarm_ring = 1'b0;
    logic       timer_done = 1'b0;
    logic [1:0] disp_sel;
    logic       stw, tmren, almen, blank, alert, mode_chg;

    int checks = 0;
    int errors = 0;
    int chg_cnt = 0;

    typedef enum int {A_MODE, A_ACK, A_TICK, A_TDONE, A_RHI, A_RLO, A_BOTH} act_e;

    typedef struct {
        act_e       act;
        logic [1:0] dsel;
        logic       blank;
        logic       alert;
        int         chg;
    } vec_t;

    vec_t vecs[$];
    vec_t exp_q[$];

    display_mode_ctrl #(.DBNC_CYC(4), .IDLE_SEC(3)) dut (
        .clk        (clk),
        .reset      (reset),
        .tick_1hz   (tick_1hz),
        .btn_mode   (btn_mode),
        .btn_ack    (btn_ack),
        .alarm_ring (alarm_ring),
        .timer_done (timer_done),
        .disp_sel   (disp_sel),
        .stw        (stw),
        .tmren      (tmren),
        .almen      (almen),
        .blank      (blank),
        .alert      (alert),
        .mode_chg   (mode_chg)
    );

    always #5 clk = ~clk;

    // Count mode_chg pulses; the value read here is the one held since the previous edge.
    always @(posedge clk) begin
        if (mode_chg) chg_cnt++;
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic add(input act_e a, input int d, input int b, input int al, input int c);
        vec_t v;
        v.act = a; v.dsel = 2'(d); v.blank = 1'(b); v.alert = 1'(al); v.chg = c;
        vecs.push_back(v);
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic run_act(input act_e a);
        case (a)
            A_MODE:  begin btn_mode = 1'b1; cycles(7); btn_mode = 1'b0; cycles(7); end
            A_ACK:   begin btn_ack = 1'b1; cycles(7); btn_ack = 1'b0; cycles(7); end
            A_TICK:  begin tick_1hz = 1'b1; cycles(1); tick_1hz = 1'b0; cycles(2); end
            A_TDONE: begin timer_done = 1'b1; cycles(1); timer_done = 1'b0; cycles(2); end
            A_RHI:   begin alarm_ring = 1'b1; cycles(3); end
            A_RLO:   begin alarm_ring = 1'b0; cycles(3); end
            A_BOTH:  begin alarm_ring = 1'b1; timer_done = 1'b1; cycles(1);
                           timer_done = 1'b0; cycles(2); end
            default: cycles(1);
        endcase
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_dsel"}, int'(disp_sel), 0);
        check({tag, "_blank"}, int'(blank), 0);
        check({tag, "_alert"}, int'(alert), 0);
        check({tag, "_sels"}, int'({stw, tmren, almen}), 0);
        check({tag, "_chg"}, int'(mode_chg), 0);
    endtask

    initial begin
        vec_t v;
        int   c0;

        // act, disp_sel, blank, alert, mode_chg pulses during the action
        add(A_MODE, 1, 0, 0, 1); add(A_MODE, 2, 0, 0, 1);
        add(A_MODE, 3, 0, 0, 1); add(A_MODE, 0, 0, 0, 1);
        add(A_MODE, 1, 0, 0, 1);
        add(A_TDONE, 2, 0, 1, 1);
        add(A_TICK, 2, 1, 1, 0); add(A_TICK, 2, 0, 1, 0); add(A_TICK, 2, 1, 1, 0);
        add(A_MODE, 2, 1, 1, 0);
        add(A_ACK, 1, 0, 0, 1);
        add(A_ACK, 1, 0, 0, 0);
        add(A_MODE, 2, 0, 0, 1); add(A_MODE, 3, 0, 0, 1);
        add(A_TICK, 3, 0, 0, 0); add(A_TICK, 3, 0, 0, 0);
        add(A_ACK, 3, 0, 0, 0);
        add(A_TICK, 3, 0, 0, 0); add(A_TICK, 3, 0, 0, 0); add(A_TICK, 0, 0, 0, 1);
        add(A_RHI, 0, 0, 1, 0); add(A_TICK, 0, 1, 1, 0); add(A_RLO, 0, 0, 0, 0);
        add(A_MODE, 1, 0, 0, 1); add(A_RHI, 0, 0, 1, 1); add(A_RLO, 1, 0, 0, 1);
        add(A_MODE, 2, 0, 0, 1); add(A_MODE, 3, 0, 0, 1); add(A_MODE, 0, 0, 0, 1);
        add(A_BOTH, 0, 0, 1, 0); add(A_ACK, 2, 0, 1, 1);
        add(A_RLO, 2, 0, 1, 0); add(A_ACK, 0, 0, 0, 1);
        add(A_RHI, 0, 0, 1, 0); add(A_TDONE, 0, 0, 1, 0);
        add(A_RLO, 2, 0, 1, 1); add(A_ACK, 0, 0, 0, 1);

        // Reset with the clock running
        #3 reset = 1'b0;
        cycles(3);
        check_all_zero("reset");
        reset = 1'b1;
        cycles(2);

        // Short bounce: 3 clk high must not register
        c0 = chg_cnt;
        btn_mode = 1'b1; cycles(3); btn_mode = 1'b0; cycles(12);
        check("short_dsel", int'(disp_sel), 0);
        check("short_chg", chg_cnt - c0, 0);

        // Six clk high: press after the 6th edge, view change on the 7th
        btn_mode = 1'b1;
        cycles(6);
        check("lat_e6_dsel", int'(disp_sel), 0);
        btn_mode = 1'b0;
        cycles(1);
        check("lat_e7_dsel", int'(disp_sel), 1);
        check("lat_e7_stw", int'(stw), 1);
        check("lat_e7_chg", int'(mode_chg), 1);
        cycles(10);

        // Back to a clean TIME state for the table
        reset = 1'b0; cycles(2); reset = 1'b1; cycles(2);
        check("rst2_dsel", int'(disp_sel), 0);

        for (int i = 0; i < vecs.size(); i++) begin
            exp_q.push_back(vecs[i]);
            c0 = chg_cnt;
            run_act(vecs[i].act);
            v = exp_q.pop_front();
            check($sformatf("v%0d_dsel", i), int'(disp_sel), int'(v.dsel));
            check($sformatf("v%0d_blank", i), int'(blank), int'(v.blank));
            check($sformatf("v%0d_alert", i), int'(alert), int'(v.alert));
            check($sformatf("v%0d_stw", i), int'(stw), int'(v.dsel == 2'd1));
            check($sformatf("v%0d_tmren", i), int'(tmren), int'(v.dsel == 2'd2));
            check($sformatf("v%0d_almen", i), int'(almen), int'(v.dsel == 2'd3));
            check($sformatf("v%0d_chg", i), chg_cnt - c0, v.chg);
        end

        // Asynchronous reset in the middle of a flashing timer alert
        run_act(A_TDONE);
        run_act(A_TICK);
        check("pre_rst_dsel", int'(disp_sel), 2);
        check("pre_rst_blank", int'(blank), 1);
        check("pre_rst_alert", int'(alert), 1);
        @(posedge clk);
        #2 reset = 1'b0;
        #1 check_all_zero("async_rst");
        cycles(2);
        reset = 1'b1;
        cycles(2);
        check("post_rst_dsel", int'(disp_sel), 0);
        check("post_rst_alert", int'(alert), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
